// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
// Arbitrating configuration controller for a single shared clk_divider.
// NREQ requesters post divide-ratio changes as level requests. The
// requests are granted round-robin, and each grant is applied with a fixed
// sequence: update rises, div changes SETUP_CYC cycles later, update falls
// HOLD_CYC cycles after that, and the winner receives a one-cycle ack
// SETTLE_CYC cycles later. A request for the ratio already applied skips
// the divider handshake and is acknowledged on the next cycle.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   nRst      synchronous active-low reset
//   req       per-requester level request, held until the matching ack
//   req_div   requested ratios, slice i = req_div[32*i+31:32*i]
//   ack       one-cycle completion pulse to the granted requester
//   busy      high in any state other than IDLE
//   grant_id  index of the current or last granted requester
//   update    to clk_divider.update
//   div       to clk_divider.div
//   cur_div   ratio currently applied and settled

module clk_div_ctrl #(
  parameter int NREQ       = 4,
  parameter int SETUP_CYC  = 5,
  parameter int HOLD_CYC   = 5,
  parameter int SETTLE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_div,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 update,
  output logic [31:0]          div,
  output logic [31:0]          cur_div
);

  // One down-counter is shared by every timed state, so it is sized for the
  // longest of the three phases.
  localparam int MAXC = (SETUP_CYC > HOLD_CYC)
                      ? ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC)
                      : ((HOLD_CYC  > SETTLE_CYC) ? HOLD_CYC  : SETTLE_CYC);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    SETTLE,
    ACK
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      grantId_q, grantId_d;
  logic [31:0]     target_q, target_d;
  logic [31:0]     div_q, div_d;
  logic [31:0]     curDiv_q, curDiv_d;

  logic            winFound;
  logic [2:0]      winIdx;
  logic [31:0]     winDiv;
  logic [2:0]      winNext;

  // Round-robin pick: the first set request at or above the pointer wins;
  // if none is found there, the search wraps and the lowest set request
  // wins. The second pass only runs when the first found nothing.
  always_comb begin
    winFound = 1'b0;
    winIdx   = 3'd0;
    winDiv   = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!winFound && req[i] && (i >= int'(ptr_q))) begin
        winFound = 1'b1;
        winIdx   = 3'(i);
        winDiv   = req_div[32*i +: 32];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!winFound && req[i]) begin
        winFound = 1'b1;
        winIdx   = 3'(i);
        winDiv   = req_div[32*i +: 32];
      end
    end
    winNext = (int'(winIdx) == NREQ - 1) ? 3'd0 : winIdx + 3'd1;
  end

  // Sequencer next-state logic. The target ratio is captured at grant time,
  // so later changes on req/req_div cannot disturb a sequence in flight.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grantId_d = grantId_q;
    target_d  = target_q;
    div_d     = div_q;
    curDiv_d  = curDiv_q;
    case (state_q)
      IDLE: begin
        if (winFound) begin
          grantId_d = winIdx;
          target_d  = winDiv;
          ptr_d     = winNext;
          if (winDiv == curDiv_q) begin
            // Ratio already applied: skip the divider handshake.
            state_d = ACK;
            cnt_d   = '0;
          end else begin
            state_d = SETUP;
            cnt_d   = CW'(SETUP_CYC - 1);
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = LOAD;
          cnt_d   = CW'(HOLD_CYC - 1);
          div_d   = target_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CW'(SETTLE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d  = ACK;
          cnt_d    = '0;
          curDiv_d = target_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        // No arbitration here; a request still high is seen in IDLE.
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= 3'd0;
      grantId_q <= 3'd0;
      target_q  <= 32'd0;
      div_q     <= 32'd0;
      curDiv_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grantId_q <= grantId_d;
      target_q  <= target_d;
      div_q     <= div_d;
      curDiv_q  <= curDiv_d;
    end
  end

  // update spans exactly the SETUP and LOAD states, so it rises on the
  // grant edge and falls on the LOAD->SETTLE edge.
  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = (state_q == ACK) && (int'(grantId_q) == i);
    end
  end

  assign busy     = (state_q != IDLE);
  assign update   = (state_q == SETUP) || (state_q == LOAD);
  assign grant_id = grantId_q;
  assign div      = div_q;
  assign cur_div  = curDiv_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl
// Directed bench for clk_div_ctrl with the default parameters. A table of
// request steps drives single requests, round-robin ordering, the
// same-ratio fast path, a zero ratio and a mid-sequence withdrawal; hand
// sequences cover a reset in the middle of a sequence and a three-way
// contention starting from reset.

module tb_clk_div_ctrl;

  localparam int NREQ = 4;
  localparam int S    = 5;
  localparam int H    = 5;
  localparam int ST   = 16;

  logic          clk;
  logic          nRst;
  logic [3:0]    req;
  logic [127:0]  req_div;
  logic [3:0]    ack;
  logic          busy;
  logic [2:0]    grant_id;
  logic          update;
  logic [31:0]   div;
  logic [31:0]   cur_div;

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   expDiv;
  logic [31:0]   expCur;

  typedef struct {
    logic [3:0]   addMask;
    logic [127:0] divs;
    int           expGrant;
    logic [31:0]  expTarget;
    int           dropK;
  } vec_t;

  vec_t vecs[9];

  clk_div_ctrl #(
    .NREQ(NREQ), .SETUP_CYC(S), .HOLD_CYC(H), .SETTLE_CYC(ST)
  ) dut (
    .clk(clk), .nRst(nRst), .req(req), .req_div(req_div), .ack(ack),
    .busy(busy), .grant_id(grant_id), .update(update), .div(div),
    .cur_div(cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eUpd,
                             input logic [31:0] eDiv, input logic [31:0] eCur,
                             input logic [3:0] eAck, input logic eBusy,
                             input logic [2:0] eGrant);
    logic [72:0] act;
    logic [72:0] exp;
    act = {update, div, cur_div, ack, busy, grant_id};
    exp = {eUpd, eDiv, eCur, eAck, eBusy, eGrant};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got upd=%0b div=%0d cur=%0d ack=%b busy=%0b gid=%0d, need upd=%0b div=%0d cur=%0d ack=%b busy=%0b gid=%0d",
               name, update, div, cur_div, ack, busy, grant_id,
               eUpd, eDiv, eCur, eAck, eBusy, eGrant);
    end
  endtask

  // Called just after the edge on which the controller sampled the request.
  // Walks the whole sequence cycle by cycle, then the first IDLE cycle,
  // where the winner drops its request.
  task automatic runSeq(input string name, input int g,
                        input logic [31:0] tgt, input int dropK);
    logic fast;
    int   last;
    logic eUpd;
    logic [31:0] eDiv;
    logic [31:0] eCur;
    logic [3:0]  eAck;
    fast = (tgt == expCur);
    last = fast ? 0 : S + H + ST;
    for (int k = 0; k <= last; k++) begin
      if (k == dropK) req[g] = 1'b0;
      eUpd = !fast && (k < S + H);
      eDiv = (!fast && k >= S) ? tgt : expDiv;
      eAck = (k == last) ? 4'(1 << g) : 4'b0000;
      eCur = (k == last) ? tgt : expCur;
      checkOutput($sformatf("%s k=%0d", name, k), eUpd, eDiv, eCur, eAck,
                  1'b1, 3'(g));
      if (k < last) tick();
    end
    if (!fast) expDiv = tgt;
    expCur = tgt;
    tick();
    req[g] = 1'b0;
    checkOutput($sformatf("%s idle", name), 1'b0, expDiv, expCur, 4'b0000,
                1'b0, 3'(g));
  endtask

  task automatic applyStimulus(input int idx);
    req     = req | vecs[idx].addMask;
    req_div = vecs[idx].divs;
    tick();
    runSeq($sformatf("vec%0d", idx), vecs[idx].expGrant, vecs[idx].expTarget,
           vecs[idx].dropK);
  endtask

  initial begin
    // Steps continue from pointer=1, cur_div=10 left by the reset test.
    vecs[0] = '{4'b0100, {32'd77, 32'd100, 32'd55, 32'd10},  2, 32'd100, -1};
    vecs[1] = '{4'b1010, {32'd77, 32'd100, 32'd55, 32'd10},  3, 32'd77,  -1};
    vecs[2] = '{4'b0000, {32'd77, 32'd100, 32'd55, 32'd10},  1, 32'd55,  -1};
    vecs[3] = '{4'b0001, {32'd77, 32'd100, 32'd55, 32'd100}, 0, 32'd100, -1};
    vecs[4] = '{4'b0010, {32'd77, 32'd100, 32'd100, 32'd100}, 1, 32'd100, -1};
    vecs[5] = '{4'b1000, {32'd0,  32'd100, 32'd100, 32'd100}, 3, 32'd0,   -1};
    vecs[6] = '{4'b0001, {32'd0,  32'd100, 32'd100, 32'd0},   0, 32'd0,   -1};
    vecs[7] = '{4'b0100, {32'd0,  32'd42,  32'd100, 32'd0},   2, 32'd42,  S + H + 3};
    vecs[8] = '{4'b0010, {32'd0,  32'd42,  32'd7,   32'd0},   1, 32'd7,   -1};

    nRst    = 1'b0;
    req     = 4'b0000;
    req_div = '0;
    expDiv  = 32'd0;
    expCur  = 32'd0;
    tick();
    tick();
    checkOutput("reset state", 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 3'd0);
    nRst = 1'b1;

    // Reset while in LOAD, then the held request reruns from scratch.
    req     = 4'b0001;
    req_div = {32'd0, 32'd0, 32'd0, 32'd10};
    tick();
    for (int k = 0; k < S + 2; k++) tick();
    checkOutput("pre-reset load", 1'b1, 32'd10, 32'd0, 4'b0000, 1'b1, 3'd0);
    nRst = 1'b0;
    tick();
    checkOutput("mid-seq reset", 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 3'd0);
    nRst = 1'b1;
    tick();
    runSeq("single", 0, 32'd10, -1);

    for (int i = 0; i < 9; i++) applyStimulus(i);

    // Three-way contention from reset: grants must come out 0, 1, 3.
    nRst = 1'b0;
    tick();
    nRst   = 1'b1;
    expDiv = 32'd0;
    expCur = 32'd0;
    checkOutput("reset again", 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 3'd0);
    req     = 4'b1011;
    req_div = {32'd0, 32'd999, 32'd100, 32'd10};
    tick();
    runSeq("cont0", 0, 32'd10, -1);
    tick();
    runSeq("cont1", 1, 32'd100, -1);
    tick();
    runSeq("cont3", 3, 32'd0, -1);
    tick();
    checkOutput("cont done", 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 3'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
